rs_dispatch_stage: RTL and testbench
====================================

Name: rs_dispatch_stage

Overview:
- Transmit end of the reservation-station dispatch interface: takes renamed micro-ops and drives RS write ports (wr_valid/wr_ready, RsBaseSt, option code) for RS_NUM reservation stations.
- Keeps a physical-register busy table so each dispatched entry arrives with correct psrc0_ready/psrc1_ready.
- Registers one micro-op in a hold stage, and applies writeback wake-ups to the held entry so no wake-up is lost while the RS stalls.
- Sits between rename and the order/out-of-order reservation stations.

Parameters:
- RS_NUM, 4, number of downstream reservation stations (one-hot select width).
- OPTION_CODE, OptionCodeSt, option-code type forwarded unchanged.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous pipeline flush.
- in_valid_i  in  1  rename micro-op valid.
- in_ready_o  out  1  stage can accept.
- rs_base_i  in  RsBaseSt  renamed base fields; valid/issued/psrc*_ready are ignored.
- option_code_i  in  OPTION_CODE  forwarded option code.
- rs_sel_i  in  RS_NUM  one-hot target RS.
- pdest_valid_i  in  1  micro-op writes a physical register.
- pdest_i  in  $clog2(`PHY_REG_NUM)  destination physical register.
- wb_pdest_valid_i  in  `WB_WIDTH  writeback valid per port.
- wb_pdest_i  in  `WB_WIDTH x $clog2(`PHY_REG_NUM)  writeback pdest per port.
- rs_wr_valid_o  out  RS_NUM  per-RS write valid.
- rs_wr_ready_i  in  RS_NUM  per-RS write ready.
- rs_base_o  out  RsBaseSt  entry to RS (shared by all RSs).
- option_code_o  out  OPTION_CODE  option code to RS.

Behaviour:
- Reset: out_valid_q=0, rs_sel_q=0, rs_base_o='0, option_code_o='0, busy table all 0 (ready), rs_wr_valid_o=0, in_ready_o=1.
- Handshake signals:
  - rs_wr_valid_o = out_valid_q ? rs_sel_q : '0.
  - fire = |(rs_wr_valid_o & rs_wr_ready_i).
  - in_ready_o = ~flush_i & (~out_valid_q | fire).
  - accept = in_valid_i & in_ready_o.
- Latency: one cycle from accept to rs_wr_valid_o. Back-to-back accept/fire sustains one micro-op per cycle.
- On accept, the hold register loads:
  - rs_base_i, with valid=1 and issued=0.
  - option_code_i and rs_sel_i.
  - psrcN_ready = ~psrcN_valid | psrcN==0 | ~busy_q[psrcN] | any j: wb_pdest_valid_i[j] & wb_pdest_i[j]==psrcN. Same-cycle bypass is mandatory.
- Hold: while out_valid_q & ~fire, all fields stay stable except wake-up. Any wb port matching a held psrcN sets psrcN_ready=1 next cycle. Ready bits never clear while held.
- Fire without accept: out_valid_q drops to 0 next cycle.
- Busy table (PHY_REG_NUM bits):
  - Accept with pdest_valid_i & pdest_i!=0 sets busy[pdest_i].
  - Each valid wb port clears busy[wb_pdest_i[j]].
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is always 0.
- rs_sel_i must be one-hot on accept. A zero or multi-hot select is illegal; the bench asserts on it. The RTL drives rs_sel_q as given.
- flush_i (synchronous, highest priority after reset):
  - Next cycle out_valid_q=0 and the busy table is cleared to all-ready.
  - Inputs in the flush cycle are ignored and there is no accept.
  - A fire in the flush cycle is still considered delivered; the RS discards it on its own flush.
  - Flush is legal only when all in-flight producers are killed too.
- Reset mid-operation: asynchronously returns all state to the reset values.

Optional Feature:
- Macro RS_DISPATCH_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o[31:0], counting cycles with out_valid_q & ~fire. Saturates at 0xFFFFFFFF.
  - Reset to 0 and cleared by flush_i.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Scheduler.svh gains RS_DISPATCH_PREG_W = $clog2(`PHY_REG_NUM) and a packed RsDispatchHoldSt {RsBaseSt base; OPTION_CODE oc; logic [RS_NUM-1:0] sel;}.
- One sub-module, phy_busy_table:
  - Set port, `WB_WIDTH clear ports, flush clear.
  - Two combinational read ports with wb bypass.
- The hold register and handshake stay in rs_dispatch_stage.

Test Plan:
- Reset release, then accept op with psrc0=5, psrc1=7 (not busy), rs_sel=4'b0010 → next cycle rs_wr_valid_o=4'b0010, both ready=1, issued=0.
- Op A pdest=9 accepted; op B psrc0=9 next cycle → B psrc0_ready=0. Then wb_pdest 9 while B is held with rs_wr_ready=0 → psrc0_ready=1 the following cycle. After that, release ready → fire.
- wb_pdest=12 in the same cycle as accept of an op with psrc1=12 and busy[12]=1 → psrc1_ready=1 (bypass).
- Same cycle accept with pdest=20 and wb of 20 → busy[20]=1 afterwards; a later op with psrc0=20 sees ready=0.
- rs_wr_ready=0 for 5 cycles with in_valid=1 → in_ready_o=0 and outputs stable. With RS_DISPATCH_STALL_CNT_EN, stall_cnt_o=5.
- flush_i while holding an op with busy regs {3,9} → next cycle rs_wr_valid_o=0, in_ready_o=1, and a new op with psrc0=9 gets ready=1.

Source files
------------

// File: rtl/rs_dispatch_stage_pkg.sv
// ----------------------------------------------------------------------------
// rs_dispatch_stage_pkg
//   Shared types for the reservation-station dispatch stage: the renamed
//   micro-op base record (RsBaseSt), the default option-code record, the
//   physical-register index width, and a writeback-match helper used both by
//   the busy table bypass and by the hold-stage wake-up.
//   `PHY_REG_NUM and `WB_WIDTH come from the scheduler configuration; the
//   defaults below apply when no configuration header has defined them.
// ----------------------------------------------------------------------------
`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif
`ifndef WB_WIDTH
`define WB_WIDTH 2
`endif

package rs_dispatch_stage_pkg;

   localparam int RS_DISPATCH_PREG_W = $clog2(`PHY_REG_NUM);

   typedef logic [RS_DISPATCH_PREG_W-1:0] preg_t;

   typedef struct packed {
      logic        valid;
      logic        issued;
      logic [5:0]  uop;
      logic        psrc0_valid;
      preg_t       psrc0;
      logic        psrc0_ready;
      logic        psrc1_valid;
      preg_t       psrc1;
      logic        psrc1_ready;
      logic        pdest_valid;
      preg_t       pdest;
      logic [7:0]  rob_idx;
   } RsBaseSt;

   typedef struct packed {
      logic [3:0] fu_op;
      logic [1:0] size;
   } OptionCodeSt;

   // Hold-stage record for the default configuration (4 RSs, OptionCodeSt).
   // The stage itself re-declares it against its own type parameters.
   typedef struct packed {
      RsBaseSt     base;
      OptionCodeSt oc;
      logic [3:0]  sel;
   } RsDispatchHoldSt;

   // True when any valid writeback port carries physical register r.
   function automatic logic preg_hit(
      input logic [`WB_WIDTH-1:0]                         v,
      input logic [`WB_WIDTH-1:0][RS_DISPATCH_PREG_W-1:0] p,
      input preg_t                                        r
   );
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < `WB_WIDTH; j++) begin
         if (v[j] && (p[j] == r)) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/rs_dispatch_stage_phy_busy_table.sv
// ----------------------------------------------------------------------------
// phy_busy_table
//   One busy bit per physical register. A dispatched producer sets its pdest
//   busy; writeback ports clear it. Two combinational read ports report
//   "ready" and include same-cycle writeback bypass.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush_i           clear the whole table to ready next cycle
//   set_valid_i       mark set_preg_i busy (set wins over a same-cycle clear)
//   set_preg_i        register to mark busy
//   wb_valid_i        per-port writeback valid
//   wb_preg_i         per-port writeback register
//   rd_preg0/1_i      read addresses
//   rd_ready0/1_o     register is not busy, is p0, or is being written back now
// ----------------------------------------------------------------------------
module phy_busy_table
   import rs_dispatch_stage_pkg::*;
(
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         flush_i,
   input  logic                                         set_valid_i,
   input  preg_t                                        set_preg_i,
   input  logic [`WB_WIDTH-1:0]                         wb_valid_i,
   input  logic [`WB_WIDTH-1:0][RS_DISPATCH_PREG_W-1:0] wb_preg_i,
   input  preg_t                                        rd_preg0_i,
   input  preg_t                                        rd_preg1_i,
   output logic                                         rd_ready0_o,
   output logic                                         rd_ready1_o
);

   logic [`PHY_REG_NUM-1:0] busy_q;
   logic [`PHY_REG_NUM-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < `WB_WIDTH; j++) begin
         if (wb_valid_i[j]) busy_d[wb_preg_i[j]] = 1'b0;
      end
      // Applied after the clears so a new producer of a register that is
      // being written back by its previous producer stays busy.
      if (set_valid_i && (set_preg_i != '0)) busy_d[set_preg_i] = 1'b1;
      busy_d[0] = 1'b0;
      if (flush_i) busy_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign rd_ready0_o = (rd_preg0_i == '0) | ~busy_q[rd_preg0_i]
                      | preg_hit(wb_valid_i, wb_preg_i, rd_preg0_i);
   assign rd_ready1_o = (rd_preg1_i == '0) | ~busy_q[rd_preg1_i]
                      | preg_hit(wb_valid_i, wb_preg_i, rd_preg1_i);

endmodule

// File: rtl/rs_dispatch_stage.sv
// ----------------------------------------------------------------------------
// rs_dispatch_stage
//   Transmit side of the reservation-station dispatch interface. Accepts one
//   renamed micro-op per cycle into a single hold register, stamps source
//   readiness from the physical-register busy table (with writeback bypass),
//   and presents it to the one-hot selected RS. While the RS stalls, the held
//   entry keeps absorbing writeback wake-ups.
//
// Optional feature (macro RS_DISPATCH_STALL_CNT_EN):
//   adds stall_cnt_o, a saturating count of cycles holding a valid entry that
//   was not taken; reset to 0 and cleared by flush_i.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush_i             synchronous flush: drop held entry, clear busy table
//   in_valid_i/in_ready_o   rename-side handshake
//   rs_base_i           renamed base fields (valid/issued/psrc*_ready ignored)
//   option_code_i       forwarded option code
//   rs_sel_i            one-hot target RS
//   pdest_valid_i, pdest_i  destination register marked busy on accept
//   wb_pdest_valid_i, wb_pdest_i  writeback ports (wake-up and busy clear)
//   rs_wr_valid_o/rs_wr_ready_i   per-RS write handshake
//   rs_base_o, option_code_o      entry shared by all RS write ports
//   stall_cnt_o         (RS_DISPATCH_STALL_CNT_EN only) stall cycle count
// ----------------------------------------------------------------------------
module rs_dispatch_stage
   import rs_dispatch_stage_pkg::*;
#(
   parameter int  RS_NUM      = 4,
   parameter type OPTION_CODE = OptionCodeSt
)(
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         flush_i,
   input  logic                                         in_valid_i,
   output logic                                         in_ready_o,
   input  RsBaseSt                                      rs_base_i,
   input  OPTION_CODE                                   option_code_i,
   input  logic [RS_NUM-1:0]                            rs_sel_i,
   input  logic                                         pdest_valid_i,
   input  preg_t                                        pdest_i,
   input  logic [`WB_WIDTH-1:0]                         wb_pdest_valid_i,
   input  logic [`WB_WIDTH-1:0][RS_DISPATCH_PREG_W-1:0] wb_pdest_i,
   output logic [RS_NUM-1:0]                            rs_wr_valid_o,
   input  logic [RS_NUM-1:0]                            rs_wr_ready_i,
   output RsBaseSt                                      rs_base_o,
   output OPTION_CODE                                   option_code_o
`ifdef RS_DISPATCH_STALL_CNT_EN
   ,
   output logic [31:0]                                  stall_cnt_o
`endif
);

   typedef struct packed {
      RsBaseSt           base;
      OPTION_CODE        oc;
      logic [RS_NUM-1:0] sel;
   } hold_t;

   hold_t hold_q, hold_d;
   logic  out_valid_q, out_valid_d;
   logic  fire;
   logic  accept;
   logic  rd_ready0, rd_ready1;

   assign rs_wr_valid_o = out_valid_q ? hold_q.sel : '0;
   assign fire          = |(rs_wr_valid_o & rs_wr_ready_i);
   assign in_ready_o    = ~flush_i & (~out_valid_q | fire);
   assign accept        = in_valid_i & in_ready_o;

   assign rs_base_o     = hold_q.base;
   assign option_code_o = hold_q.oc;

   phy_busy_table u_busy (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .set_valid_i (accept & pdest_valid_i),
      .set_preg_i  (pdest_i),
      .wb_valid_i  (wb_pdest_valid_i),
      .wb_preg_i   (wb_pdest_i),
      .rd_preg0_i  (rs_base_i.psrc0),
      .rd_preg1_i  (rs_base_i.psrc1),
      .rd_ready0_o (rd_ready0),
      .rd_ready1_o (rd_ready1)
   );

   // rename -> hold stage boundary
   always_comb begin
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         hold_d.base             = rs_base_i;
         hold_d.base.valid       = 1'b1;
         hold_d.base.issued      = 1'b0;
         hold_d.base.psrc0_ready = ~rs_base_i.psrc0_valid | rd_ready0;
         hold_d.base.psrc1_ready = ~rs_base_i.psrc1_valid | rd_ready1;
         hold_d.oc               = option_code_i;
         hold_d.sel              = rs_sel_i;
         out_valid_d             = 1'b1;
      end else begin
         if (fire) out_valid_d = 1'b0;
         // Wake-up only ever sets ready bits; a held entry never loses one.
         if (preg_hit(wb_pdest_valid_i, wb_pdest_i, hold_q.base.psrc0))
            hold_d.base.psrc0_ready = 1'b1;
         if (preg_hit(wb_pdest_valid_i, wb_pdest_i, hold_q.base.psrc1))
            hold_d.base.psrc1_ready = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
      end
   end

`ifdef RS_DISPATCH_STALL_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (flush_i)                   stall_cnt_d = '0;
      else if (out_valid_q && !fire) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rs_dispatch_stage.sv
module tb_rs_dispatch_stage;
   import rs_dispatch_stage_pkg::*;

   logic                                         clk;
   logic                                         rst_n;
   logic                                         flush_i;
   logic                                         in_valid_i;
   logic                                         in_ready_o;
   RsBaseSt                                      rs_base_i;
   OptionCodeSt                                  option_code_i;
   logic [3:0]                                   rs_sel_i;
   logic                                         pdest_valid_i;
   preg_t                                        pdest_i;
   logic [`WB_WIDTH-1:0]                         wb_pdest_valid_i;
   logic [`WB_WIDTH-1:0][RS_DISPATCH_PREG_W-1:0] wb_pdest_i;
   logic [3:0]                                   rs_wr_valid_o;
   logic [3:0]                                   rs_wr_ready_i;
   RsBaseSt                                      rs_base_o;
   OptionCodeSt                                  option_code_o;
`ifdef RS_DISPATCH_STALL_CNT_EN
   logic [31:0]                                  stall_cnt_o;
`endif

   rs_dispatch_stage #(.RS_NUM(4), .OPTION_CODE(OptionCodeSt)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .flush_i          (flush_i),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .rs_base_i        (rs_base_i),
      .option_code_i    (option_code_i),
      .rs_sel_i         (rs_sel_i),
      .pdest_valid_i    (pdest_valid_i),
      .pdest_i          (pdest_i),
      .wb_pdest_valid_i (wb_pdest_valid_i),
      .wb_pdest_i       (wb_pdest_i),
      .rs_wr_valid_o    (rs_wr_valid_o),
      .rs_wr_ready_i    (rs_wr_ready_i),
      .rs_base_o        (rs_base_o),
      .option_code_o    (option_code_o)
`ifdef RS_DISPATCH_STALL_CNT_EN
      ,
      .stall_cnt_o      (stall_cnt_o)
`endif
   );

   typedef struct {
      logic [3:0] sel;
      logic       r0;
      logic       r1;
      logic [5:0] oc;
      logic [7:0] rob;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic RsBaseSt mk_base(input logic [7:0] rob, input logic p0v, input logic [5:0] p0,
                                       input logic p1v, input logic [5:0] p1,
                                       input logic pdv, input logic [5:0] pd);
      RsBaseSt b;
      b             = '0;
      b.valid       = 1'b0;   // junk values the stage must override
      b.issued      = 1'b1;
      b.psrc0_ready = 1'b1;
      b.psrc1_ready = 1'b0;
      b.uop         = rob[5:0];
      b.psrc0_valid = p0v;
      b.psrc0       = p0;
      b.psrc1_valid = p1v;
      b.psrc1       = p1;
      b.pdest_valid = pdv;
      b.pdest       = pd;
      b.rob_idx     = rob;
      return b;
   endfunction

   function automatic logic [5:0] mk_oc(input logic [7:0] rob);
      return rob[5:0] ^ 6'h2A;
   endfunction

   task automatic drive(input logic [7:0] rob, input logic p0v, input logic [5:0] p0,
                        input logic p1v, input logic [5:0] p1,
                        input logic pdv, input logic [5:0] pd, input logic [3:0] sel);
      rs_base_i     = mk_base(rob, p0v, p0, p1v, p1, pdv, pd);
      option_code_i = OptionCodeSt'(mk_oc(rob));
      rs_sel_i      = sel;
      pdest_valid_i = pdv;
      pdest_i       = pd;
      in_valid_i    = 1'b1;
   endtask

   // Present an op, wait (bounded) for in_ready_o, record its expectation.
   task automatic issue(input logic [7:0] rob, input logic p0v, input logic [5:0] p0,
                        input logic p1v, input logic [5:0] p1,
                        input logic pdv, input logic [5:0] pd, input logic [3:0] sel,
                        input logic er0, input logic er1);
      exp_t e;
      logic ok;
      drive(rob, p0v, p0, p1v, p1, pdv, pd, sel);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout rob %0d: in_ready_o stayed 0, required 1", rob);
      end else begin
         e.sel = sel; e.r0 = er0; e.r1 = er1; e.oc = mk_oc(rob); e.rob = rob;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid_i    = 1'b0;
      pdest_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Scoreboard monitor: every delivered entry is matched against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && |(rs_wr_valid_o & rs_wr_ready_i)) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_dispatch: actual rob %0d, required none", rs_base_o.rob_idx);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("dispatch_rob%0d", e.rob),
                  {24'd0, rs_wr_valid_o, rs_base_o.psrc0_ready, rs_base_o.psrc1_ready,
                   rs_base_o.valid, rs_base_o.issued, option_code_o, rs_base_o.rob_idx},
                  {24'd0, e.sel, e.r0, e.r1, 1'b1, 1'b0, e.oc, e.rob});
         end
      end
   end

   always @(posedge clk) begin
      if (rst_n && in_valid_i && in_ready_o)
         assert ($onehot(rs_sel_i)) else $error("rs_sel_i not one-hot on accept");
   end

   initial begin
      RsBaseSt eb;
      rst_n            = 1'b0;
      flush_i          = 1'b0;
      in_valid_i       = 1'b0;
      rs_base_i        = '0;
      option_code_i    = '0;
      rs_sel_i         = '0;
      pdest_valid_i    = 1'b0;
      pdest_i          = '0;
      wb_pdest_valid_i = '0;
      wb_pdest_i       = '0;
      rs_wr_ready_i    = 4'hF;

      // Reset state
      @(negedge clk);
      check("reset_wr_valid", {60'd0, rs_wr_valid_o}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready_o}, 64'd1);
      check("reset_base", {25'd0, rs_base_o}, 64'd0);
      check("reset_oc", {58'd0, option_code_o}, 64'd0);
`ifdef RS_DISPATCH_STALL_CNT_EN
      check("reset_stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
`endif
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic dispatch, sources not busy
      issue(8'd1, 1'b1, 6'd5, 1'b1, 6'd7, 1'b0, 6'd0, 4'b0010, 1'b1, 1'b1);
      @(negedge clk);
      check("t1_wr_valid", {60'd0, rs_wr_valid_o}, 64'h2);
      idle(1);

      // Busy dependency, then wake-up while held
      issue(8'd2, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9, 4'b0001, 1'b1, 1'b1);
      issue(8'd3, 1'b1, 6'd9, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0100, 1'b1, 1'b1);
      rs_wr_ready_i = 4'h0;
      @(negedge clk);
      check("t2_held_r0_busy", {63'd0, rs_base_o.psrc0_ready}, 64'd0);
      check("t2_held_wr_valid", {60'd0, rs_wr_valid_o}, 64'h4);
      check("t2_held_in_ready", {63'd0, in_ready_o}, 64'd0);
      @(posedge clk); #1;
      wb_pdest_valid_i[0] = 1'b1;
      wb_pdest_i[0]       = 6'd9;
      @(negedge clk);
      check("t2_wake_not_yet", {63'd0, rs_base_o.psrc0_ready}, 64'd0);
      @(posedge clk); #1;
      wb_pdest_valid_i = '0;
      @(negedge clk);
      check("t2_wake_r0", {63'd0, rs_base_o.psrc0_ready}, 64'd1);
      @(posedge clk); #1;
      rs_wr_ready_i = 4'hF;

      // Same-cycle writeback bypass on accept
      issue(8'd4, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd12, 4'b1000, 1'b1, 1'b1);
      wb_pdest_valid_i[1] = 1'b1;
      wb_pdest_i[1]       = 6'd12;
      issue(8'd5, 1'b0, 6'd0, 1'b1, 6'd12, 1'b0, 6'd0, 4'b0010, 1'b1, 1'b1);
      wb_pdest_valid_i = '0;

      // Set and clear of the same register in one cycle: set wins
      wb_pdest_valid_i[0] = 1'b1;
      wb_pdest_i[0]       = 6'd20;
      issue(8'd6, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd20, 4'b0001, 1'b1, 1'b1);
      wb_pdest_valid_i = '0;
      issue(8'd7, 1'b1, 6'd20, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0100, 1'b0, 1'b1);
      idle(1);

      // Flush with busy {3,9,20} and an entry held
      issue(8'd9, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 6'd3, 4'b0010, 1'b1, 1'b1);
      issue(8'd10, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd9, 4'b0001, 1'b1, 1'b1);
      rs_wr_ready_i = 4'h0;
      @(posedge clk); #1;
      flush_i = 1'b1;
      drive(8'd12, 1'b0, 6'd0, 1'b0, 6'd0, 1'b1, 6'd5, 4'b0001);
      @(negedge clk);
      check("flush_in_ready", {63'd0, in_ready_o}, 64'd0);
      void'(exp_q.pop_back());   // held op 10 is dropped by the flush
      @(posedge clk); #1;
      flush_i       = 1'b0;
      in_valid_i    = 1'b0;
      pdest_valid_i = 1'b0;
      rs_wr_ready_i = 4'hF;
      @(negedge clk);
      check("post_flush_wr_valid", {60'd0, rs_wr_valid_o}, 64'd0);
      check("post_flush_in_ready", {63'd0, in_ready_o}, 64'd1);
`ifdef RS_DISPATCH_STALL_CNT_EN
      check("post_flush_stall_cnt", {32'd0, stall_cnt_o}, 64'd0);
`endif
      @(posedge clk); #1;
      issue(8'd11, 1'b1, 6'd9, 1'b1, 6'd3, 1'b0, 6'd0, 4'b0100, 1'b1, 1'b1);
      idle(1);

      // Five-cycle stall with the next op waiting
      rs_wr_ready_i = 4'h0;
      issue(8'd13, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 6'd0, 4'b0010, 1'b1, 1'b1);
      eb             = mk_base(8'd13, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 6'd0);
      eb.valid       = 1'b1;
      eb.issued      = 1'b0;
      eb.psrc0_ready = 1'b1;
      eb.psrc1_ready = 1'b1;
      drive(8'd14, 1'b0, 6'd0, 1'b1, 6'd20, 1'b0, 6'd0, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("stall%0d_in_ready", i), {63'd0, in_ready_o}, 64'd0);
         check($sformatf("stall%0d_wr_valid", i), {60'd0, rs_wr_valid_o}, 64'h2);
         check($sformatf("stall%0d_entry", i), {19'd0, rs_base_o, option_code_o},
               {19'd0, eb, mk_oc(8'd13)});
      end
      @(negedge clk);
`ifdef RS_DISPATCH_STALL_CNT_EN
      check("stall_cnt_5", {32'd0, stall_cnt_o}, 64'd5);
`endif
      @(posedge clk); #1;
      rs_wr_ready_i = 4'hF;
      issue(8'd14, 1'b0, 6'd0, 1'b1, 6'd20, 1'b0, 6'd0, 4'b1000, 1'b1, 1'b1);
      idle(3);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
